// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: auto-scrolling rotation index for an 8-to-1 display mux.
// Optional macro HEX_SCROLL_BOUNCE_EN switches from modulo-8 wrap to ping-pong
// scrolling using an internal direction register.
module hex_scroll_ctrl #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       DIR,
    input  logic       LOAD,
    input  logic [2:0] LOAD_POS,
    output logic [2:0] SEL,
    output logic       STEP,
    output logic       WRAP,
    output logic       BUSY
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [2:0]    sel_d;
    logic          step_d, wrap_d;

    // candidate result of one automatic step
    logic          step_up;
    logic [2:0]    step_sel;
    logic          step_wrap;

`ifdef HEX_SCROLL_BOUNCE_EN
    logic          dir_q, dir_d;

    // ping-pong: reverse at the ends, WRAP flags arrival at an end position
    always_comb begin
        step_up = ~dir_q;
        if (step_up && (SEL == 3'd7)) begin
            step_up = 1'b0;
        end else if (!step_up && (SEL == 3'd0)) begin
            step_up = 1'b1;
        end
        step_sel  = step_up ? 3'(SEL + 3'd1) : 3'(SEL - 3'd1);
        step_wrap = step_up ? (step_sel == 3'd7) : (step_sel == 3'd0);
    end
`else
    // modulo-8 stepping straight from DIR, WRAP flags the 7<->0 crossing
    always_comb begin
        step_up   = ~DIR;
        step_sel  = step_up ? 3'(SEL + 3'd1) : 3'(SEL - 3'd1);
        step_wrap = step_up ? (SEL == 3'd7) : (SEL == 3'd0);
    end
`endif

    // next-state, prescaler and output decode; LOAD overrides SEL/prescaler last
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sel_d   = SEL;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
`ifdef HEX_SCROLL_BOUNCE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (START && !STOP) begin
                    state_d = RUN;
                    presc_d = '0;
`ifdef HEX_SCROLL_BOUNCE_EN
                    dir_d   = DIR;
`endif
                end
            end
            RUN: begin
                if (STOP) begin
                    state_d = PAUSED;
                end else if (presc_q == TERM) begin
                    presc_d = '0;
                    sel_d   = step_sel;
                    step_d  = 1'b1;
                    wrap_d  = step_wrap;
`ifdef HEX_SCROLL_BOUNCE_EN
                    dir_d   = ~step_up;
`endif
                end else begin
                    presc_d = CW'(presc_q + 1'b1);
                end
            end
            PAUSED: begin
                if (STOP) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    presc_d = '0;
                end else if (START) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                sel_d   = 3'd0;
            end
        endcase
        if (LOAD) begin
            sel_d   = LOAD_POS;
            presc_d = '0;
            step_d  = 1'b0;
            wrap_d  = 1'b0;
`ifdef HEX_SCROLL_BOUNCE_EN
            dir_d   = DIR;
`endif
        end
    end

    // state and registered outputs, synchronous reset overrides everything
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            presc_q <= '0;
            SEL     <= 3'd0;
            STEP    <= 1'b0;
            WRAP    <= 1'b0;
            BUSY    <= 1'b0;
`ifdef HEX_SCROLL_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            SEL     <= sel_d;
            STEP    <= step_d;
            WRAP    <= wrap_d;
            BUSY    <= (state_d == RUN);
`ifdef HEX_SCROLL_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl (default build, TICK_DIV=4).
module tb_hex_scroll_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET, START, STOP, DIR, LOAD;
    logic [2:0] LOAD_POS;
    logic [2:0] SEL;
    logic       STEP, WRAP, BUSY;

    int errors = 0;
    int checks = 0;

    hex_scroll_ctrl #(.TICK_DIV(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .START    (START),
        .STOP     (STOP),
        .DIR      (DIR),
        .LOAD     (LOAD),
        .LOAD_POS (LOAD_POS),
        .SEL      (SEL),
        .STEP     (STEP),
        .WRAP     (WRAP),
        .BUSY     (BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // advance one edge, then settle 1 ns past it
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] s, input logic st,
                           input logic wr, input logic bz);
        chk({tag, ".sel"},  4'(SEL),  4'(s));
        chk({tag, ".step"}, 4'(STEP), 4'(st));
        chk({tag, ".wrap"}, 4'(WRAP), 4'(wr));
        chk({tag, ".busy"}, 4'(BUSY), 4'(bz));
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; STOP = 1'b0; DIR = 1'b0;
        LOAD = 1'b0; LOAD_POS = 3'd0;
        tick(2);
        chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // no counting until START
        RESET = 1'b0;
        tick(3);
        chk_out("idle_no_start", 3'd0, 1'b0, 1'b0, 1'b0);

        // START pulse, DIR=0: steps at cycles 4, 8, 12
        START = 1'b1;
        tick(1);
        START = 1'b0;
        chk_out("run_entry", 3'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(3);
            chk_out("run_wait", 3'(k - 1), 1'b0, 1'b0, 1'b1);
            tick(1);
            chk_out("run_step", 3'(k), 1'b1, 1'b0, 1'b1);
        end

        // LOAD 7 then step up wraps to 0
        LOAD = 1'b1; LOAD_POS = 3'd7;
        tick(1);
        LOAD = 1'b0;
        chk_out("load7", 3'd7, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk_out("wrap_up", 3'd0, 1'b1, 1'b1, 1'b1);

        // DIR=1 from 0 wraps to 7, then 6
        DIR = 1'b1;
        tick(4);
        chk_out("wrap_down", 3'd7, 1'b1, 1'b1, 1'b1);
        tick(4);
        chk_out("down_step", 3'd6, 1'b1, 1'b0, 1'b1);

        // STOP at prescaler=2, resume 10 cycles later, step 2 cycles after resume
        tick(2);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        chk_out("paused", 3'd6, 1'b0, 1'b0, 1'b0);
        tick(10);
        chk_out("paused_hold", 3'd6, 1'b0, 1'b0, 1'b0);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        chk_out("resume", 3'd6, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("resume_wait", 3'd6, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("resume_step", 3'd5, 1'b1, 1'b0, 1'b1);

        // STOP twice: RUN->PAUSED->IDLE clears SEL
        STOP = 1'b1;
        tick(1);
        chk_out("stop1", 3'd5, 1'b0, 1'b0, 1'b0);
        tick(1);
        STOP = 1'b0;
        chk_out("stop2_idle", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(5);
        chk_out("idle_quiet", 3'd0, 1'b0, 1'b0, 1'b0);

        // LOAD on the same edge as a due step
        DIR = 1'b0;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(3);
        LOAD = 1'b1; LOAD_POS = 3'd5;
        tick(1);
        LOAD = 1'b0;
        chk_out("load_over_step", 3'd5, 1'b0, 1'b0, 1'b1);
        tick(3);
        chk_out("post_load_wait", 3'd5, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("post_load_step", 3'd6, 1'b1, 1'b0, 1'b1);

        // START and STOP together in RUN -> PAUSED
        START = 1'b1; STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        chk_out("start_stop", 3'd6, 1'b0, 1'b0, 1'b0);

        // resume with coincident LOAD 3, then RESET mid-RUN
        LOAD = 1'b1; LOAD_POS = 3'd3;
        tick(1);
        START = 1'b0; LOAD = 1'b0;
        chk_out("resume_load3", 3'd3, 1'b0, 1'b0, 1'b1);
        tick(2);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        chk_out("reset_mid_run", 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("post_reset_step", 4'(STEP), 4'd0);
        end
        chk_out("post_reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // modulo wrap from LOAD_POS=6: 7, 0 (WRAP), 1
        LOAD = 1'b1; LOAD_POS = 3'd6;
        tick(1);
        LOAD = 1'b0;
        chk_out("load6_idle", 3'd6, 1'b0, 1'b0, 1'b0);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(4);
        chk_out("seq7", 3'd7, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk_out("seq0", 3'd0, 1'b1, 1'b1, 1'b1);
        tick(4);
        chk_out("seq1", 3'd1, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning clock cycles per scroll step (0.5 s at 50 MHz); legal range 2..2^26.
REQ-002 SHALL have port CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port START  in  1  start or resume scrolling; level sampled each cycle.
REQ-005 SHALL have port STOP  in  1  pause, or return to idle if already paused.
REQ-006 SHALL have port DIR  in  1  step direction: 0 = SEL increments, 1 = SEL decrements.
REQ-007 SHALL have port LOAD  in  1  force SEL to LOAD_POS.
REQ-008 SHALL have port LOAD_POS  in  3  position loaded on LOAD.
REQ-009 SHALL have port SEL  out  3  rotation index driven to the 8-to-1 display mux selects (replaces SW[17:15]).
REQ-010 SHALL have port STEP  out  1  one-cycle pulse coincident with each automatic SEL change.
REQ-011 SHALL have port WRAP  out  1  one-cycle pulse coincident with a STEP that crosses an end position.
REQ-012 SHALL have port BUSY  out  1  high while state = RUN.

Function
REQ-013 SHALL implement states IDLE, RUN and PAUSED with a prescaler counter of ceil(log2(TICK_DIV)) bits.
REQ-014 SHALL transition IDLE->RUN on START, clearing the prescaler.
REQ-015 SHALL transition RUN->PAUSED on STOP, holding the prescaler and SEL.
REQ-016 SHALL transition PAUSED->RUN on START, resuming from the held prescaler value.
REQ-017 SHALL transition PAUSED->IDLE on STOP, setting SEL to 0 and clearing the prescaler.
REQ-018 SHALL give STOP priority when START and STOP are high in the same cycle; the state takes the STOP transition.
REQ-019 SHALL increment the prescaler in RUN only; on the edge where it equals TICK_DIV-1, SHALL reset it to 0, step SEL by +/-1 per DIR and register STEP=1.
REQ-020 SHALL make the first step appear TICK_DIV cycles after the edge that enters RUN from IDLE.
REQ-021 SHALL wrap SEL modulo 8 (7+1 -> 0, 0-1 -> 7) and assert WRAP with that STEP.
REQ-022 SHALL, on LOAD in any state, load SEL<=LOAD_POS and clear the prescaler without changing state; no STEP or WRAP is asserted.
REQ-023 SHALL give LOAD priority over a coincident prescaler step; a coincident START or STOP still takes effect.
REQ-024 SHALL hold STEP and WRAP low in IDLE and PAUSED; SHALL have no combinational input-to-output path.

Reset
REQ-025 SHALL, when RESET is high at a clock edge, set state=IDLE, prescaler=0, SEL=0, STEP=0, WRAP=0 and BUSY=0, overriding all other inputs, including mid-RUN.
REQ-026 SHALL start counting after reset only on a subsequent START.

Configuration
REQ-027 SHALL support macro HEX_SCROLL_BOUNCE_EN, which enables ping-pong scrolling.
REQ-028 SHALL, with HEX_SCROLL_BOUNCE_EN defined, use an internal direction register loaded from DIR on IDLE->RUN and on LOAD.
REQ-029 SHALL, with HEX_SCROLL_BOUNCE_EN defined, reverse that register when a step would move past 7 or 0, so the sequence runs 6,7,6 and 1,0,1; WRAP pulses on the step that reaches the end position.
REQ-030 SHALL, with HEX_SCROLL_BOUNCE_EN defined, ignore DIR at all other times.
REQ-031 SHALL, without HEX_SCROLL_BOUNCE_EN, use DIR directly every step with modulo-8 wrap per REQ-021 and synthesise no direction register.

Verification
REQ-032 SHALL cover: TICK_DIV=4, reset, START pulse, DIR=0 -> STEP at cycles 4, 8, 12...; SEL 1, 2, 3...; BUSY=1 from the cycle after START.
REQ-033 SHALL cover: DIR=0, SEL=7 at a step -> SEL=0 with STEP=1 and WRAP=1 in the same cycle; DIR=1, SEL=0 -> SEL=7 with WRAP=1.
REQ-034 SHALL cover: STOP at prescaler=2 -> PAUSED, SEL held; START 10 cycles later -> next step 2 cycles after resume; a second STOP from PAUSED -> IDLE with SEL=0.
REQ-035 SHALL cover: LOAD with LOAD_POS=5 on the same edge as a due step -> SEL=5, STEP=0, next step TICK_DIV cycles later; START and STOP together in RUN -> PAUSED.
REQ-036 SHALL cover: RESET asserted mid-RUN with SEL=3 -> next cycle SEL=0, BUSY=0, no STEP until START.
REQ-037 SHALL cover: HEX_SCROLL_BOUNCE_EN defined, LOAD_POS=6, DIR=0, START -> SEL 7 (WRAP=1), 6, 5...; undefined -> SEL 7, 0 (WRAP=1), 1.
